// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode/reset constants and saturating step helper for pwm_multicanal
package pwm_pkg;
  localparam logic MODO_MANUAL = 1'b0;
  localparam logic MODO_REF    = 1'b1;
  localparam int   NF_RST      = 1;

  // Opposing presses or no press hold the value; otherwise move by step, clamped to [lo, hi].
  function automatic logic [31:0] sat_step(input logic [31:0] val, input logic up, input logic dn,
                                           input logic [31:0] step, input logic [31:0] lo,
                                           input logic [31:0] hi);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    sat_step = val;
    if (up && !dn) begin
      sat_step = (sum > {1'b0, hi}) ? hi : sum[31:0];
    end else if (dn && !up) begin
      sat_step = (val < lo + step) ? lo : val - step;
    end
  endfunction
endpackage

// File: rtl/pwm_canal.sv
// rtl/pwm_canal.sv - one PWM channel: manual duty, period-boundary shadow, compare flop
// PWM_PHASE_STAGGER_EN offsets this channel's compare count by IDX * 2^CNT_W / N_CH.
module pwm_canal
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int STEP  = 1,
  parameter int N_CH  = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             dn,
  input  logic             load,
  input  logic             modo,
  input  logic [CNT_W-1:0] ref_duty,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] shadow,
  output logic             pwm
);
`ifdef PWM_PHASE_STAGGER_EN
  localparam logic [CNT_W-1:0] OFFSET = CNT_W'(IDX * ((1 << CNT_W) / N_CH));
`else
  localparam logic [CNT_W-1:0] OFFSET = '0;
`endif
  localparam logic [31:0] DUTY_MAX = 32'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] manual;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] cnt_k;

  assign eff   = (modo == MODO_REF) ? ref_duty : manual;
  assign cnt_k = cnt + OFFSET;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      manual <= '0;
      shadow <= '0;
      pwm    <= 1'b0;
    end else if (en) begin
      manual <= CNT_W'(sat_step(32'(manual), up, dn, 32'(STEP), 32'd0, DUTY_MAX));
      if (load) shadow <= eff;
      pwm <= (cnt_k < shadow);
    end else begin
      pwm <= 1'b0;
    end
  end
endmodule

// File: rtl/pwm_multicanal.sv
// rtl/pwm_multicanal.sv - multi-channel PWM top: buttons, frequency index, prescaler, counter
// Optional PWM_PHASE_STAGGER_EN (see pwm_canal) staggers channel phases.
module pwm_multicanal
  import pwm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 8,
  parameter int NF_MAX = 255,
  parameter int STEP   = 1,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  CLKNEXYS,
  input  logic                  MRst,
  input  logic                  MEn,
  input  logic                  Modo_i,
  input  logic                  aumf_i,
  input  logic                  bajaf_i,
  input  logic                  aumC_i,
  input  logic                  bajaC_i,
  input  logic [SEL_W-1:0]      Sel_ch_i,
  input  logic [N_CH*CNT_W-1:0] REF,
  output logic [DIV_W-1:0]      numF_o,
  output logic [CNT_W-1:0]      duty_o,
  output logic [N_CH-1:0]       SALIDAM
);
  logic [3:0]       btn;
  logic [3:0]       btn_q;
  logic [3:0]       press;
  logic [DIV_W-1:0] numf;
  logic [DIV_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             wrap;
  logic [CNT_W-1:0] shadow_arr [N_CH];

  assign btn   = {bajaC_i, aumC_i, bajaf_i, aumf_i};
  assign press = btn & ~btn_q & {4{MEn}};
  assign tick  = MEn && (pre >= numf);
  assign wrap  = tick && (cnt == '1);

  // Edge registers reset high and keep tracking while disabled so held buttons never count.
  always_ff @(posedge CLKNEXYS or negedge MRst) begin
    if (!MRst) begin
      btn_q <= '1;
      numf  <= DIV_W'(NF_RST);
      pre   <= '0;
      cnt   <= '0;
    end else begin
      btn_q <= btn;
      if (MEn) begin
        numf <= DIV_W'(sat_step(32'(numf), press[0], press[1], 32'd1, 32'(NF_RST), 32'(NF_MAX)));
        pre  <= tick ? '0 : pre + 1'b1;
        if (tick) cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_canal #(.CNT_W(CNT_W), .STEP(STEP), .N_CH(N_CH), .IDX(k)) u_canal (
      .clk      (CLKNEXYS),
      .rst_n    (MRst),
      .en       (MEn),
      .up       (press[2] && (Sel_ch_i == SEL_W'(k))),
      .dn       (press[3] && (Sel_ch_i == SEL_W'(k))),
      .load     (wrap),
      .modo     (Modo_i),
      .ref_duty (REF[k*CNT_W +: CNT_W]),
      .cnt      (cnt),
      .shadow   (shadow_arr[k]),
      .pwm      (SALIDAM[k])
    );
  end

  always_comb begin
    duty_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (Sel_ch_i == SEL_W'(k)) duty_o = shadow_arr[k];
    end
  end

  assign numF_o = numf;
endmodule

// File: tb/tb_pwm_multicanal.sv
// tb/tb_pwm_multicanal.sv - scoreboard bench for pwm_multicanal (N_CH=2, CNT_W=4), both stagger builds
module tb_pwm_multicanal;
  localparam int N_CH = 2, CNT_W = 4, DIV_W = 8, NF_MAX = 255, STEP = 1;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int OFF1 = 8;
`else
  localparam int OFF1 = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       men = 1'b1;
  logic       modo = 1'b0;
  logic       aumf = 1'b0, bajaf = 1'b0, aumc = 1'b0, bajac = 1'b0;
  logic [0:0] sel = 1'b0;
  logic [7:0] ref_bus = 8'h00;
  logic [7:0] numf;
  logic [3:0] duty;
  logic [1:0] salida;

  typedef struct {
    int    kind;
    int    exp;
    string name;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  bit ok;

  pwm_multicanal #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_W(DIV_W), .NF_MAX(NF_MAX), .STEP(STEP)) dut (
    .CLKNEXYS (clk),
    .MRst     (rst_n),
    .MEn      (men),
    .Modo_i   (modo),
    .aumf_i   (aumf),
    .bajaf_i  (bajaf),
    .aumC_i   (aumc),
    .bajaC_i  (bajac),
    .Sel_ch_i (sel),
    .REF      (ref_bus),
    .numF_o   (numf),
    .duty_o   (duty),
    .SALIDAM  (salida)
  );

  always #5 clk = ~clk;

  // Monitor: drains every expectation queued during the current cycle at the falling edge.
  initial begin : monitor
    item_t it;
    int    act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          0:       act = int'(numf);
          1:       act = int'(duty);
          default: act = int'(salida);
        endcase
        checks++;
        if (act != it.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input int exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    {bajac, aumc, bajaf, aumf} = m;
    step();
    {bajac, aumc, bajaf, aumf} = 4'b0000;
    step();
  endtask

  task automatic wait_cycles(input int n);
    for (int n_i = 0; n_i < n; n_i++) step();
  endtask

  // Lands on the first cycle SALIDAM[0] is high after being low (index i = 0 of the model).
  task automatic align(output bit found);
    logic prev;
    found = 1'b0;
    for (int n_i = 0; n_i < 80; n_i++) begin
      prev = salida[0];
      step();
      if (!prev && salida[0]) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL align: ch0 rising edge seen=%0d required=1 within 80 cycles", found);
    end
  endtask

  // numF=1: cnt steps every 2 cycles; output at i reflects cnt = i/2 compared with the duty.
  function automatic int model(input int i, input int d0, input int d1);
    int b0, b1;
    b0 = (((i / 2) % 16) < d0) ? 1 : 0;
    b1 = ((((i / 2) + OFF1) % 16) < d1) ? 1 : 0;
    return b1 * 2 + b0;
  endfunction

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    aumf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val(0, 1, "rst_numf");
      expect_val(2, 0, "rst_salida");
      expect_val(1, 0, "rst_duty");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_val(0, 1, "held_aumf_numf");
      expect_val(2, 0, "held_aumf_salida");
    end
    aumf = 1'b0;
    step();
    expect_val(0, 1, "release_numf");

    press(4'b0001); expect_val(0, 2, "aumf_numf");
    press(4'b0010); expect_val(0, 1, "bajaf1_numf");
    press(4'b0010); expect_val(0, 1, "bajaf2_numf");
    press(4'b0010); expect_val(0, 1, "bajaf3_numf");
    press(4'b0001); expect_val(0, 2, "aumf_again_numf");
    press(4'b0011); expect_val(0, 2, "both_f_numf");
    press(4'b0010); expect_val(0, 1, "back_to_1_numf");
    for (int n = 1; n <= 300; n++) begin
      press(4'b0001);
      expect_val(0, (n + 1 > 255) ? 255 : n + 1, $sformatf("aumf_sat_%0d", n));
    end
    for (int n = 0; n < 254; n++) press(4'b0010);
    expect_val(0, 1, "numf_down_to_1");

    sel = 1'b1;
    press(4'b1000);
    for (int n = 0; n < 8; n++) press(4'b0100);
    sel = 1'b0;
    for (int n = 0; n < 8; n++) press(4'b0100);
    press(4'b1100);
    wait_cycles(70);
    align(ok);
    expect_val(1, 8, "manual_duty_ch0");
    for (int i = 0; i < 48; i++) begin
      if (i > 0) step();
      expect_val(2, model(i, 8, 8), $sformatf("manual_salida_i%0d", i));
    end
    sel = 1'b1;
    expect_val(1, 8, "manual_duty_ch1");

    modo = 1'b1;
    ref_bus = {4'd4, 4'd8};
    wait_cycles(70);
    align(ok);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) step();
      if (i == 8) ref_bus = {4'd12, 4'd8};
      expect_val(2, model(i, 8, (i < 32) ? 4 : 12), $sformatf("ref_salida_i%0d", i));
      if (i == 30) expect_val(1, 4, "ref_duty_before_wrap");
      if (i == 31) expect_val(1, 12, "ref_duty_after_wrap");
    end

    align(ok);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      expect_val(2, model(i, 8, 12), $sformatf("pre_dis_salida_i%0d", i));
    end
    men = 1'b0;
    for (int j = 5; j < 15; j++) begin
      step();
      if (j == 6) aumf = 1'b1;
      if (j == 7) aumf = 1'b0;
      expect_val(2, 0, $sformatf("dis_salida_j%0d", j));
      if (j == 14) men = 1'b1;
    end
    for (int j = 15; j < 51; j++) begin
      step();
      expect_val(2, model(j - 10, 8, 12), $sformatf("resume_salida_j%0d", j));
      if (j == 15) expect_val(0, 1, "dis_press_ignored_numf");
    end

    press(4'b0001);
    press(4'b0001);
    expect_val(0, 3, "pre_reset_numf");
    align(ok);
    rst_n = 1'b0;
    #1;
    expect_val(0, 1, "async_rst_numf");
    expect_val(2, 0, "async_rst_salida");
    expect_val(1, 0, "async_rst_duty");
    step();
    rst_n = 1'b1;
    step();
    expect_val(0, 1, "post_rst_numf");
    expect_val(1, 0, "post_rst_duty");

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
